// File: rtl/add_pipe_32.sv
// Two-stage 32-bit adder/subtractor: byte-sliced carry-lookahead partials in S1,
// inter-slice carry resolve in S2. Define ADD_PIPE_FLAGS_EN to build the status flags.

module add_pipe_32_cla8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_g,
    output logic       o_p
);

    logic [7:0] w_gen;
    logic [7:0] w_prop;

    assign w_gen  = i_a & i_b;
    assign w_prop = i_a | i_b;
    assign o_p    = &w_prop;

    always_comb begin : sum_and_group
        logic w_c;
        logic w_gg;
        w_c   = i_cin;
        w_gg  = 1'b0;
        o_sum = '0;
        for (int i = 0; i < 8; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = w_gen[i] | (w_prop[i] & w_c);
            // Group generate ignores the slice carry-in; it is folded in later in S2.
            w_gg     = w_gen[i] | (w_prop[i] & w_gg);
        end
        o_g = w_gg;
    end

endmodule

module add_pipe_32 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_carry,
    output logic        out_overflow,
    output logic        out_zero,
    output logic        out_negative
);

    // Handshake: a beat transfers on a rising edge where valid && ready; a producer
    // holding valid keeps its payload stable until that edge, and ready never looks at valid.

    logic [31:0]      w_b_eff;
    logic [3:0][7:0]  w_part;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic             w_s1_ld;
    logic             w_s2_ld;

    logic             r_s1_valid;
    logic [3:0][7:0]  r_s1_part;
    logic [3:0]       r_s1_g;
    logic [3:0]       r_s1_p;
    logic             r_s1_sub;

    logic             r_out_valid;
    logic [31:0]      r_out_result;

    logic             w_c8;
    logic             w_c16;
    logic             w_c24;
    logic [31:0]      w_result;

    assign w_b_eff = in_sub ? ~in_b : in_b;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_slice
            add_pipe_32_cla8 u_cla8 (
                .i_a   (in_a[8*k +: 8]),
                .i_b   (w_b_eff[8*k +: 8]),
                .i_cin ((k == 0) ? in_sub : 1'b0),
                .o_sum (w_part[k]),
                .o_g   (w_g[k]),
                .o_p   (w_p[k])
            );
        end
    endgenerate

    assign w_s2_ld  = r_s1_valid && (!r_out_valid || out_ready);
    assign w_s1_ld  = !r_s1_valid || w_s2_ld;
    assign in_ready = reset_n && w_s1_ld;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_part  <= '0;
            r_s1_g     <= '0;
            r_s1_p     <= '0;
            r_s1_sub   <= 1'b0;
        end else if (w_s1_ld) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_part <= w_part;
                r_s1_g    <= w_g;
                r_s1_p    <= w_p;
                r_s1_sub  <= in_sub;
            end
        end
    end

    assign w_c8  = r_s1_g[0] | (r_s1_p[0] & r_s1_sub);
    assign w_c16 = r_s1_g[1] | (r_s1_p[1] & w_c8);
    assign w_c24 = r_s1_g[2] | (r_s1_p[2] & w_c16);

    assign w_result = {r_s1_part[3] + {7'd0, w_c24},
                       r_s1_part[2] + {7'd0, w_c16},
                       r_s1_part[1] + {7'd0, w_c8},
                       r_s1_part[0]};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else if (w_s2_ld) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_result;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;

`ifdef ADD_PIPE_FLAGS_EN
    logic r_s1_a31;
    logic r_s1_b31;
    logic w_c32;
    logic r_out_carry;
    logic r_out_overflow;
    logic r_out_zero;
    logic r_out_negative;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_a31 <= 1'b0;
            r_s1_b31 <= 1'b0;
        end else if (w_s1_ld && in_valid) begin
            r_s1_a31 <= in_a[31];
            r_s1_b31 <= w_b_eff[31];
        end
    end

    assign w_c32 = r_s1_g[3] | (r_s1_p[3] & w_c24);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_carry    <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_zero     <= 1'b0;
            r_out_negative <= 1'b0;
        end else if (w_s2_ld) begin
            r_out_carry    <= w_c32;
            r_out_overflow <= (r_s1_a31 == r_s1_b31) && (w_result[31] != r_s1_a31);
            r_out_zero     <= (w_result == 32'd0);
            r_out_negative <= w_result[31];
        end
    end

    assign out_carry    = r_out_carry;
    assign out_overflow = r_out_overflow;
    assign out_zero     = r_out_zero;
    assign out_negative = r_out_negative;
`else
    // Top-slice group terms only feed the carry flag, which this build drops.
    logic w_unused_gp3;
    assign w_unused_gp3 = r_s1_g[3] ^ r_s1_p[3];

    assign out_carry    = 1'b0;
    assign out_overflow = 1'b0;
    assign out_zero     = 1'b0;
    assign out_negative = 1'b0;
`endif

endmodule

// File: tb/tb_add_pipe_32.sv
// Bench for add_pipe_32: directed corner cases, randomized streaming with
// back-pressure against an arithmetic reference model, and mid-flight reset.

module tb_add_pipe_32;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;
    logic        out_negative;

    logic [35:0] w_obs;
    logic [35:0] exp_q[$];
    int          n_pass;
    int          n_total;
    int          acc_cycles;

    assign w_obs = {out_result, out_carry, out_overflow, out_zero, out_negative};

    add_pipe_32 dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_negative (out_negative)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] res;
        logic        c;
        logic        v;
        longint      sa;
        if (sub) begin
            res = a - b;
            c   = (a >= b);
            sa  = longint'($signed(a)) - longint'($signed(b));
        end else begin
            {c, res} = {1'b0, a} + {1'b0, b};
            sa  = longint'($signed(a)) + longint'($signed(b));
        end
        v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
`ifdef ADD_PIPE_FLAGS_EN
        return {res, c, v, (res == 32'd0), res[31]};
`else
        return {res, 4'b0000};
`endif
    endfunction

    function automatic logic [35:0] flags_exp(input logic [31:0] res, input logic [3:0] f);
`ifdef ADD_PIPE_FLAGS_EN
        return {res, f};
`else
        return {res, 4'b0000};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Driver: one isolated beat, checking the two-edge latency.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [35:0] exp);
        @(negedge clock);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clock);
        #1;
        check({tag, "_lat2_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(w_obs), 64'(exp));
    endtask

    task automatic drain();
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
    endtask

    // Driver + scoreboard: random beats with random back-pressure.
    task automatic stream(input string tag, input int n, input int vpct, input int rpct,
                          output int acc_cyc);
        int          acc;
        int          cyc;
        logic        held;
        logic [35:0] held_val;
        logic [35:0] e;
        acc     = 0;
        cyc     = 0;
        acc_cyc = 0;
        held    = 1'b0;
        held_val = '0;
        while ((acc < n || exp_q.size() > 0) && cyc < 400) begin
            @(negedge clock);
            in_valid  = (acc < n) && ($urandom_range(99) < vpct);
            in_a      = $urandom;
            in_b      = $urandom;
            in_sub    = 1'($urandom_range(1));
            out_ready = ($urandom_range(99) < rpct);
            #1;
            check({tag, "_in_ready"}, 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
            if (held)
                check({tag, "_hold"}, 64'({out_valid, w_obs}), 64'({1'b1, held_val}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_spurious"}, 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_data"}, 64'(w_obs), 64'(e));
                end
            end
            held     = out_valid && !out_ready;
            held_val = w_obs;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_sub));
                acc++;
                if (acc == n) acc_cyc = cyc + 1;
            end
            @(posedge clock);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_all_accepted"}, 64'(acc), 64'(n));
        check({tag, "_all_emitted"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h1234_5678;
        in_b      = 32'h0000_0001;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        // Reset state: nothing accepted even with in_valid high.
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'(w_obs), 64'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases with hand-derived results.
        do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, flags_exp(32'h0000_0000, 4'b1010));
        do_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, flags_exp(32'h8000_0000, 4'b0101));
        do_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, flags_exp(32'hFFFF_FFFE, 4'b0001));
        do_op("sub_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, flags_exp(32'h0000_0000, 4'b1010));
        do_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, flags_exp(32'h7FFF_FFFF, 4'b1100));
        do_op("add_bytecarry", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, flags_exp(32'h0100_0000, 4'b0000));
        drain();

        // Full-rate streaming: one accept per cycle.
        stream("tput", 8, 100, 100, acc_cycles);
        check("tput_cycles", 64'(acc_cycles), 64'd8);

        // Random valid and ready.
        stream("rand", 16, 70, 50, acc_cycles);
        stream("stall", 16, 100, 25, acc_cycles);

        // Mid-flight reset: two beats in the pipe, then reset for one edge.
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h1111_1111;
        in_b      = 32'h2222_2222;
        in_sub    = 1'b0;
        @(posedge clock);
        @(negedge clock);
        in_a = 32'h3333_3333;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("mid_two_in_flight", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outputs", 64'(w_obs), 64'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check("mid_no_stale", 64'(out_valid), 64'd0);
        end

        // Recovery after reset.
        do_op("add_wrap_again", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, flags_exp(32'h0000_0000, 4'b1010));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/add_pipe_32.md
ADD_PIPE_32 -- requirements
Module: add_pipe_32

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, built from four 8-bit slices.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand beat present.
REQ-005 in_ready  output  1  block accepts beat this cycle.
REQ-006 in_a  input  32  operand A.
REQ-007 in_b  input  32  operand B.
REQ-008 in_sub  input  1  1 = A-B, 0 = A+B.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_result  output  32  sum/difference, mod 2^32.
REQ-012 out_carry  output  1  carry out of bit 31; on subtract, 1 = no borrow.
REQ-013 out_overflow  output  1  signed overflow.
REQ-014 out_zero  output  1  out_result == 0.
REQ-015 out_negative  output  1  out_result[31].

Function
REQ-016 Stage 1 (S1) SHALL form B' = in_sub ? ~in_b : in_b and feed bytes of in_a/B' into four instances of the team's 8-bit carry-lookahead slice (outputs: 8-bit result, group G, group P = AND of bitwise OR-propagates).
REQ-017 Slice 0 carry-in SHALL be in_sub; slices 1-3 carry-in SHALL be 0.
REQ-018 S1 register SHALL capture 4 partial bytes, G[3:0], P[3:0], in_sub, in_a[31], B'[31] on accept (in_valid && in_ready).
REQ-019 Stage 2 (S2) SHALL compute from S1 registers: c8 = G0|(P0&sub); c16 = G1|(P1&c8); c24 = G2|(P2&c16); c32 = G3|(P3&c24).
REQ-020 S2 SHALL form byte0 = partial0, byte k = partial k + c(8k) mod 256 for k = 1..3.
REQ-021 overflow SHALL be (a31 == b'31) && (result[31] != a31); carry SHALL be c32.
REQ-022 S2 output register SHALL hold all out_* signals; latency accept-to-out_valid exactly 2 cycles with no stall.
REQ-023 S2 load enable = S1 valid && (!out_valid || out_ready); S1 load enable = !S1 valid || S2 load enable; in_ready SHALL equal S1 load enable (combinational, no dependence on in_valid).
REQ-024 Sustained throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-025 While out_valid && !out_ready, all out_* SHALL hold stable; with both stages full, in_ready SHALL be 0 and no beat SHALL be lost or duplicated.
REQ-026 Simultaneous output-pop and input-push with both stages full SHALL advance both stages in the same cycle.
REQ-027 Beats SHALL leave in acceptance order.

Reset
REQ-028 reset_n low at a rising edge SHALL clear S1 valid, out_valid, out_result, and all flags to 0, discarding in-flight beats.
REQ-029 During reset in_ready SHALL be 0; first accept possible on the first edge after reset_n returns high.

Configuration
REQ-030 Macro ADD_PIPE_FLAGS_EN defined: out_carry, out_overflow, out_zero, out_negative computed per REQ-021/014/015 and registered in S2.
REQ-031 Macro ADD_PIPE_FLAGS_EN undefined: flag ports remain present but SHALL be constant 0, flag logic and S1 sign-bit registers omitted; out_result/handshake unchanged.

Verification
REQ-032 add 0xFFFFFFFF+0x00000001 -> result 0x00000000, carry 1, zero 1, overflow 0, 2 cycles after accept.
REQ-033 add 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow 1, negative 1, carry 0; sub 5-7 -> 0xFFFFFFFE, carry 0, negative 1.
REQ-034 Stream 16 random beats with out_ready toggled pseudo-randomly -> outputs match golden model in order, none dropped, in_ready 0 only when both stages full.
REQ-035 Accept 2 beats, assert reset_n low one cycle mid-flight -> out_valid 0 after reset, no stale beat emitted.
REQ-036 Build without ADD_PIPE_FLAGS_EN, rerun REQ-032 -> result 0x00000000, all flags 0.
